// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle control FSM: states, instruction classes,
// opcodes, ALU operation classes and datapath mux selects.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
        EXEC, RWB, BRANCH, JUMP, IEXEC, IWB, TRAP
    } state_t;

    typedef enum logic [2:0] {
        CLS_RTYPE, CLS_MEM, CLS_BRANCH, CLS_JUMP, CLS_IMM, CLS_ILLEGAL
    } op_class_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_FUNCT = 4'd2;
    localparam logic [3:0] ALU_AND   = 4'd3;
    localparam logic [3:0] ALU_OR    = 4'd4;
    localparam logic [3:0] ALU_SLT   = 4'd5;

    localparam logic [1:0] REG_DST_RT = 2'b00;
    localparam logic [1:0] REG_DST_RD = 2'b01;
    localparam logic [1:0] REG_DST_RA = 2'b10;

    localparam logic       SRC_A_PC = 1'b0;
    localparam logic       SRC_A_RS = 1'b1;

    localparam logic [1:0] SRC_B_REG     = 2'b00;
    localparam logic [1:0] SRC_B_FOUR    = 2'b01;
    localparam logic [1:0] SRC_B_IMM     = 2'b10;
    localparam logic [1:0] SRC_B_IMM_SH2 = 2'b11;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    localparam logic       EXT_ZERO = 1'b0;
    localparam logic       EXT_SIGN = 1'b1;

endpackage

// File: rtl/mc_op_decode.sv
// Opcode classifier: picks the dispatch class used by DECODE and the ALU
// operation / immediate extension used by the immediate-arithmetic states.
module mc_op_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    output op_class_t  op_class,
    output logic [3:0] imm_alu_op,
    output logic       imm_ext_mode
);

    always_comb begin
        op_class     = CLS_ILLEGAL;
        imm_alu_op   = ALU_ADD;
        imm_ext_mode = EXT_SIGN;
        case (opcode)
            OP_RTYPE:      op_class = CLS_RTYPE;
            OP_LW, OP_SW:  op_class = CLS_MEM;
            OP_BEQ, OP_BNE: op_class = CLS_BRANCH;
            OP_J, OP_JAL:  op_class = CLS_JUMP;
            OP_ADDI:       op_class = CLS_IMM;
            OP_SLTI: begin
                op_class   = CLS_IMM;
                imm_alu_op = ALU_SLT;
            end
            // Logical immediates take their constant zero-extended.
            OP_ANDI: begin
                op_class     = CLS_IMM;
                imm_alu_op   = ALU_AND;
                imm_ext_mode = EXT_ZERO;
            end
            OP_ORI: begin
                op_class     = CLS_IMM;
                imm_alu_op   = ALU_OR;
                imm_ext_mode = EXT_ZERO;
            end
            default: op_class = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multi-cycle datapath: sequences fetch/decode/execute
// over a shared memory port, traps on bad opcodes or memory timeouts, counts retirements.
module multicycle_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [5:0]       i_opcode,
    input  logic             i_mem_ready,
    output logic             o_pc_write,
    output logic             o_pc_write_cond,
    output logic             o_branch_ne,
    output logic             o_iord,
    output logic             o_mem_read,
    output logic             o_mem_write,
    output logic             o_ir_write,
    output logic [1:0]       o_reg_dst,
    output logic             o_mem_to_reg,
    output logic             o_pc_to_reg,
    output logic             o_reg_write,
    output logic             o_alu_src_a,
    output logic [1:0]       o_alu_src_b,
    output logic [3:0]       o_alu_op,
    output logic             o_ext_mode,
    output logic [1:0]       o_pc_source,
    output logic             o_illegal,
    output logic             o_bus_err,
    output logic [CNT_W-1:0] o_retired
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;
    op_class_t         op_class;
    logic [3:0]        imm_alu_op;
    logic              imm_ext_mode;

    mc_op_decode u_op_decode (
        .opcode       (i_opcode),
        .op_class     (op_class),
        .imm_alu_op   (imm_alu_op),
        .imm_ext_mode (imm_ext_mode)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= FETCH;
            wait_cnt  <= '0;
            o_illegal <= 1'b0;
            o_bus_err <= 1'b0;
            o_retired <= '0;
        end else begin
            case (state)
                // Memory-access states: completion wins over a timeout on the same cycle.
                FETCH, MEMRD, MEMWR: begin
                    if (i_mem_ready) begin
                        wait_cnt <= '0;
                        if (state == FETCH) begin
                            state <= DECODE;
                        end else if (state == MEMRD) begin
                            state <= MEMWB;
                        end else begin
                            state     <= FETCH;
                            o_retired <= o_retired + CNT_W'(1);
                        end
                    end else if (wait_cnt == WAIT_LAST) begin
                        wait_cnt  <= '0;
                        state     <= TRAP;
                        o_bus_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                DECODE: begin
                    case (op_class)
                        CLS_RTYPE:  state <= EXEC;
                        CLS_MEM:    state <= MEMADR;
                        CLS_BRANCH: state <= BRANCH;
                        CLS_JUMP:   state <= JUMP;
                        CLS_IMM:    state <= IEXEC;
                        default: begin
                            state     <= TRAP;
                            o_illegal <= 1'b1;
                        end
                    endcase
                end
                MEMADR: state <= (i_opcode == OP_SW) ? MEMWR : MEMRD;
                EXEC:   state <= RWB;
                IEXEC:  state <= IWB;
                MEMWB, RWB, BRANCH, JUMP, IWB: begin
                    state     <= FETCH;
                    o_retired <= o_retired + CNT_W'(1);
                end
                default: state <= TRAP;
            endcase
        end
    end

    // Moore decode of the current state; only FETCH's IR/PC loads look at the handshake.
    always_comb begin
        o_pc_write      = 1'b0;
        o_pc_write_cond = 1'b0;
        o_branch_ne     = 1'b0;
        o_iord          = 1'b0;
        o_mem_read      = 1'b0;
        o_mem_write     = 1'b0;
        o_ir_write      = 1'b0;
        o_reg_dst       = REG_DST_RT;
        o_mem_to_reg    = 1'b0;
        o_pc_to_reg     = 1'b0;
        o_reg_write     = 1'b0;
        o_alu_src_a     = SRC_A_PC;
        o_alu_src_b     = SRC_B_REG;
        o_alu_op        = ALU_ADD;
        o_ext_mode      = EXT_ZERO;
        o_pc_source     = PC_SRC_ALU;
        case (state)
            FETCH: begin
                o_mem_read  = 1'b1;
                o_alu_src_b = SRC_B_FOUR;
                o_ir_write  = i_mem_ready;
                o_pc_write  = i_mem_ready;
            end
            DECODE: begin
                o_alu_src_b = SRC_B_IMM_SH2;
                o_ext_mode  = EXT_SIGN;
            end
            MEMADR: begin
                o_alu_src_a = SRC_A_RS;
                o_alu_src_b = SRC_B_IMM;
                o_ext_mode  = EXT_SIGN;
            end
            MEMRD: begin
                o_iord     = 1'b1;
                o_mem_read = 1'b1;
            end
            MEMWB: begin
                o_mem_to_reg = 1'b1;
                o_reg_write  = 1'b1;
            end
            MEMWR: begin
                o_iord      = 1'b1;
                o_mem_write = 1'b1;
            end
            EXEC: begin
                o_alu_src_a = SRC_A_RS;
                o_alu_op    = ALU_FUNCT;
            end
            RWB: begin
                o_reg_dst   = REG_DST_RD;
                o_reg_write = 1'b1;
            end
            BRANCH: begin
                o_alu_src_a     = SRC_A_RS;
                o_alu_op        = ALU_SUB;
                o_pc_write_cond = 1'b1;
                o_pc_source     = PC_SRC_ALUOUT;
                o_branch_ne     = (i_opcode == OP_BNE);
            end
            // jal writes back the PC that FETCH already advanced.
            JUMP: begin
                o_pc_source = PC_SRC_JUMP;
                o_pc_write  = 1'b1;
                if (i_opcode == OP_JAL) begin
                    o_reg_dst   = REG_DST_RA;
                    o_pc_to_reg = 1'b1;
                    o_reg_write = 1'b1;
                end
            end
            IEXEC: begin
                o_alu_src_a = SRC_A_RS;
                o_alu_src_b = SRC_B_IMM;
                o_alu_op    = imm_alu_op;
                o_ext_mode  = imm_ext_mode;
            end
            IWB: begin
                o_reg_write = 1'b1;
                o_alu_op    = imm_alu_op;
                o_ext_mode  = imm_ext_mode;
            end
            default: ;
        endcase
        if (i_rst) begin
            o_pc_write      = 1'b0;
            o_pc_write_cond = 1'b0;
            o_mem_read      = 1'b0;
            o_mem_write     = 1'b0;
            o_ir_write      = 1'b0;
            o_reg_write     = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: latency table, hand-written corner sequences and a
// randomized instruction stream checked cycle by cycle against an instruction-level model.
module tb_multicycle_ctrl;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_ne;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic [1:0] reg_dst;
        logic       mem_to_reg;
        logic       pc_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_op;
        logic       ext_mode;
        logic [1:0] pc_source;
    } ctl_t;

    typedef struct {
        string      name;
        logic [5:0] op;
        int         mem_wait;
        int         cycles;
    } lat_vec_t;

    logic        i_clk;
    logic        i_rst;
    logic [5:0]  i_opcode;
    logic        i_mem_ready;
    logic        o_pc_write, o_pc_write_cond, o_branch_ne, o_iord;
    logic        o_mem_read, o_mem_write, o_ir_write;
    logic [1:0]  o_reg_dst;
    logic        o_mem_to_reg, o_pc_to_reg, o_reg_write, o_alu_src_a;
    logic [1:0]  o_alu_src_b;
    logic [3:0]  o_alu_op;
    logic        o_ext_mode;
    logic [1:0]  o_pc_source;
    logic        o_illegal, o_bus_err;
    logic [31:0] o_retired;

    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_retired;
    logic        exp_illegal;
    logic        exp_bus_err;
    logic        plan_rdy[$];
    ctl_t        plan_ctl[$];
    lat_vec_t    lat_tab[13];
    logic [5:0]  legal_ops[11];

    multicycle_ctrl #(.CNT_W(32), .TIMEOUT(16)) dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_opcode        (i_opcode),
        .i_mem_ready     (i_mem_ready),
        .o_pc_write      (o_pc_write),
        .o_pc_write_cond (o_pc_write_cond),
        .o_branch_ne     (o_branch_ne),
        .o_iord          (o_iord),
        .o_mem_read      (o_mem_read),
        .o_mem_write     (o_mem_write),
        .o_ir_write      (o_ir_write),
        .o_reg_dst       (o_reg_dst),
        .o_mem_to_reg    (o_mem_to_reg),
        .o_pc_to_reg     (o_pc_to_reg),
        .o_reg_write     (o_reg_write),
        .o_alu_src_a     (o_alu_src_a),
        .o_alu_src_b     (o_alu_src_b),
        .o_alu_op        (o_alu_op),
        .o_ext_mode      (o_ext_mode),
        .o_pc_source     (o_pc_source),
        .o_illegal       (o_illegal),
        .o_bus_err       (o_bus_err),
        .o_retired       (o_retired)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got no finish, required finish before 2000000 ns");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic ctl_t actualCtl();
        ctl_t c;
        c.pc_write      = o_pc_write;
        c.pc_write_cond = o_pc_write_cond;
        c.branch_ne     = o_branch_ne;
        c.iord          = o_iord;
        c.mem_read      = o_mem_read;
        c.mem_write     = o_mem_write;
        c.ir_write      = o_ir_write;
        c.reg_dst       = o_reg_dst;
        c.mem_to_reg    = o_mem_to_reg;
        c.pc_to_reg     = o_pc_to_reg;
        c.reg_write     = o_reg_write;
        c.alu_src_a     = o_alu_src_a;
        c.alu_src_b     = o_alu_src_b;
        c.alu_op        = o_alu_op;
        c.ext_mode      = o_ext_mode;
        c.pc_source     = o_pc_source;
        return c;
    endfunction

    // Expected control words of the individual instruction steps.
    function automatic ctl_t fetchCtl(input logic done);
        ctl_t c = '0;
        c.mem_read  = 1'b1;
        c.alu_src_b = 2'b01;
        c.ir_write  = done;
        c.pc_write  = done;
        return c;
    endfunction

    function automatic ctl_t decodeCtl();
        ctl_t c = '0;
        c.alu_src_b = 2'b11;
        c.ext_mode  = 1'b1;
        return c;
    endfunction

    function automatic ctl_t memCtl(input logic write);
        ctl_t c = '0;
        c.iord      = 1'b1;
        c.mem_read  = ~write;
        c.mem_write = write;
        return c;
    endfunction

    task automatic applyStimulus(input logic rdy, input logic [5:0] op);
        @(negedge i_clk);
        i_mem_ready = rdy;
        i_opcode    = op;
        #1;
    endtask

    task automatic checkOutput(input string name, input ctl_t exp);
        ctl_t act;
        act = actualCtl();
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s ctl: got %h required %h", name, act, exp);
        end
        total++;
        if ({o_illegal, o_bus_err} !== {exp_illegal, exp_bus_err}) begin
            bad++;
            $display("[TB] FAIL %s flags(illegal,bus_err): got %b%b required %b%b",
                     name, o_illegal, o_bus_err, exp_illegal, exp_bus_err);
        end
        total++;
        if (o_retired !== exp_retired) begin
            bad++;
            $display("[TB] FAIL %s retired: got %0d required %0d", name, o_retired, exp_retired);
        end
    endtask

    // One-cycle reset pulse; strobes must already be quiet while it is held.
    task automatic doReset();
        @(negedge i_clk);
        i_rst       = 1'b1;
        i_mem_ready = 1'b1;
        #1;
        total++;
        if ({o_pc_write, o_pc_write_cond, o_mem_read, o_mem_write, o_ir_write, o_reg_write} !== 6'b0) begin
            bad++;
            $display("[TB] FAIL reset_strobes: got %b required 000000",
                     {o_pc_write, o_pc_write_cond, o_mem_read, o_mem_write, o_ir_write, o_reg_write});
        end
        @(posedge i_clk);
        #1;
        i_rst       = 1'b0;
        i_mem_ready = 1'b0;
        exp_retired = '0;
        exp_illegal = 1'b0;
        exp_bus_err = 1'b0;
    endtask

    // Instruction-level model: expands one instruction into its expected per-cycle
    // (ready, control) sequence, with fw/mw cycles of memory stall.
    task automatic planInstr(input logic [5:0] op, input int fw, input int mw);
        ctl_t       c;
        logic [3:0] ao;
        logic       em;
        for (int k = 0; k <= fw; k++) begin
            plan_rdy.push_back(k == fw);
            plan_ctl.push_back(fetchCtl(k == fw));
        end
        plan_rdy.push_back(1'($urandom_range(0, 1)));
        plan_ctl.push_back(decodeCtl());
        case (op)
            6'b000000: begin
                c = '0; c.alu_src_a = 1'b1; c.alu_op = 4'd2;
                plan_rdy.push_back(1'($urandom_range(0, 1))); plan_ctl.push_back(c);
                c = '0; c.reg_dst = 2'b01; c.reg_write = 1'b1;
                plan_rdy.push_back(1'($urandom_range(0, 1))); plan_ctl.push_back(c);
            end
            6'b100011, 6'b101011: begin
                c = '0; c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.ext_mode = 1'b1;
                plan_rdy.push_back(1'($urandom_range(0, 1))); plan_ctl.push_back(c);
                for (int k = 0; k <= mw; k++) begin
                    plan_rdy.push_back(k == mw);
                    plan_ctl.push_back(memCtl(op == 6'b101011));
                end
                if (op == 6'b100011) begin
                    c = '0; c.mem_to_reg = 1'b1; c.reg_write = 1'b1;
                    plan_rdy.push_back(1'($urandom_range(0, 1))); plan_ctl.push_back(c);
                end
            end
            6'b000100, 6'b000101: begin
                c = '0; c.alu_src_a = 1'b1; c.alu_op = 4'd1; c.pc_write_cond = 1'b1;
                c.pc_source = 2'b01; c.branch_ne = (op == 6'b000101);
                plan_rdy.push_back(1'($urandom_range(0, 1))); plan_ctl.push_back(c);
            end
            6'b000010, 6'b000011: begin
                c = '0; c.pc_source = 2'b10; c.pc_write = 1'b1;
                if (op == 6'b000011) begin
                    c.reg_dst = 2'b10; c.pc_to_reg = 1'b1; c.reg_write = 1'b1;
                end
                plan_rdy.push_back(1'($urandom_range(0, 1))); plan_ctl.push_back(c);
            end
            default: begin
                ao = (op == 6'b001010) ? 4'd5 : (op == 6'b001100) ? 4'd3 :
                     (op == 6'b001101) ? 4'd4 : 4'd0;
                em = !(op == 6'b001100 || op == 6'b001101);
                c = '0; c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_op = ao; c.ext_mode = em;
                plan_rdy.push_back(1'($urandom_range(0, 1))); plan_ctl.push_back(c);
                c = '0; c.reg_write = 1'b1; c.alu_op = ao; c.ext_mode = em;
                plan_rdy.push_back(1'($urandom_range(0, 1))); plan_ctl.push_back(c);
            end
        endcase
    endtask

    task automatic runPlan(input logic [5:0] op, input string name);
        logic r;
        ctl_t c;
        while (plan_rdy.size() > 0) begin
            r = plan_rdy.pop_front();
            c = plan_ctl.pop_front();
            applyStimulus(r, op);
            checkOutput(name, c);
        end
        exp_retired = exp_retired + 32'd1;
    endtask

    initial begin
        int cyc;
        int waited;
        logic [31:0] start;
        logic [5:0] op;
        int fw;
        int mw;

        lat_tab[0]  = '{"lat_rtype", 6'b000000, 0, 4};
        lat_tab[1]  = '{"lat_lw",    6'b100011, 0, 5};
        lat_tab[2]  = '{"lat_sw",    6'b101011, 0, 4};
        lat_tab[3]  = '{"lat_beq",   6'b000100, 0, 3};
        lat_tab[4]  = '{"lat_bne",   6'b000101, 0, 3};
        lat_tab[5]  = '{"lat_j",     6'b000010, 0, 3};
        lat_tab[6]  = '{"lat_jal",   6'b000011, 0, 3};
        lat_tab[7]  = '{"lat_addi",  6'b001000, 0, 4};
        lat_tab[8]  = '{"lat_slti",  6'b001010, 0, 4};
        lat_tab[9]  = '{"lat_andi",  6'b001100, 0, 4};
        lat_tab[10] = '{"lat_ori",   6'b001101, 0, 4};
        lat_tab[11] = '{"lat_lw_w3", 6'b100011, 3, 8};
        lat_tab[12] = '{"lat_sw_w2", 6'b101011, 2, 6};
        legal_ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101, 6'b000010,
                      6'b000011, 6'b001000, 6'b001010, 6'b001100, 6'b001101};

        i_rst = 1'b1;
        i_opcode = 6'b0;
        i_mem_ready = 1'b0;
        doReset();

        applyStimulus(1'b0, 6'b000000);
        checkOutput("after_reset", fetchCtl(1'b0));

        // Latency table: cycles from FETCH until the retired count moves.
        @(negedge i_clk);
        #1;
        for (int t = 0; t < 13; t++) begin
            cyc = 0;
            waited = 0;
            start = o_retired;
            i_opcode = lat_tab[t].op;
            while (cyc < 40) begin
                if (o_retired != start) break;
                if (o_iord && waited < lat_tab[t].mem_wait) begin
                    i_mem_ready = 1'b0;
                    waited++;
                end else begin
                    i_mem_ready = 1'b1;
                end
                cyc++;
                @(negedge i_clk);
                #1;
            end
            total++;
            if (cyc != lat_tab[t].cycles) begin
                bad++;
                $display("[TB] FAIL %s: got %0d cycles required %0d", lat_tab[t].name, cyc, lat_tab[t].cycles);
            end
        end
        i_mem_ready = 1'b0;
        total++;
        if (o_retired !== 32'd13) begin
            bad++;
            $display("[TB] FAIL lat_retired: got %0d required 13", o_retired);
        end
        exp_retired = 32'd13;

        // Reset in the middle of a stalled load.
        applyStimulus(1'b1, 6'b100011);
        checkOutput("midrd_fetch", fetchCtl(1'b1));
        applyStimulus(1'b1, 6'b100011);
        checkOutput("midrd_decode", decodeCtl());
        applyStimulus(1'b1, 6'b100011);
        applyStimulus(1'b0, 6'b100011);
        checkOutput("midrd_memrd", memCtl(1'b0));
        doReset();
        applyStimulus(1'b0, 6'b100011);
        checkOutput("midrd_after_reset", fetchCtl(1'b0));

        doReset();
        planInstr(6'b000101, 0, 0); runPlan(6'b000101, "seq_bne");
        planInstr(6'b000011, 0, 0); runPlan(6'b000011, "seq_jal");
        planInstr(6'b001101, 0, 0); runPlan(6'b001101, "seq_ori");
        planInstr(6'b100011, 0, 3); runPlan(6'b100011, "seq_lw_wait3");
        planInstr(6'b000000, 15, 0); runPlan(6'b000000, "seq_fetch_ready_at_limit");
        planInstr(6'b101011, 0, 15); runPlan(6'b101011, "seq_sw_ready_at_limit");

        for (int n = 0; n < 80; n++) begin
            op = legal_ops[$urandom_range(0, 10)];
            fw = ($urandom_range(0, 7) == 0) ? 15 : $urandom_range(0, 3);
            mw = ($urandom_range(0, 7) == 0) ? 15 : $urandom_range(0, 3);
            planInstr(op, fw, mw);
            runPlan(op, "rand");
        end

        // Undefined opcode traps and stays quiet.
        applyStimulus(1'b1, 6'b111111);
        checkOutput("illegal_fetch", fetchCtl(1'b1));
        applyStimulus(1'b1, 6'b111111);
        checkOutput("illegal_decode", decodeCtl());
        exp_illegal = 1'b1;
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'($urandom_range(0, 1)), 6'b111111);
            checkOutput("illegal_trap", '0);
        end
        doReset();

        // Fetch that never completes.
        for (int k = 0; k < 16; k++) begin
            applyStimulus(1'b0, 6'b000000);
            checkOutput("fetch_timeout_wait", fetchCtl(1'b0));
        end
        exp_bus_err = 1'b1;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'($urandom_range(0, 1)), 6'b000000);
            checkOutput("fetch_timeout_trap", '0);
        end
        doReset();

        // Store that never completes.
        applyStimulus(1'b1, 6'b101011);
        applyStimulus(1'b1, 6'b101011);
        applyStimulus(1'b1, 6'b101011);
        for (int k = 0; k < 16; k++) begin
            applyStimulus(1'b0, 6'b101011);
            checkOutput("sw_timeout_wait", memCtl(1'b1));
        end
        exp_bus_err = 1'b1;
        applyStimulus(1'b1, 6'b101011);
        checkOutput("sw_timeout_trap", '0);
        doReset();
        applyStimulus(1'b0, 6'b000000);
        checkOutput("final_after_reset", fetchCtl(1'b0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Moore-style main control FSM that sequences the CPU datapath as a multi-cycle machine. It replaces the single-cycle combinational control decode.
- One shared memory port for instructions and data, reached through an IorD select.
- One ALU, reused for PC+4, branch target, address and execute.
It emits per-state mux selects and write enables, waits on a memory-ready handshake, and counts retired instructions.

Parameters:
CNT_W, 32, width of retired-instruction counter
TIMEOUT, 16, max cycles to wait for i_mem_ready before bus-error trap (must be >=1)

Ports:
i_clk  in  1  clock, all state on rising edge
i_rst  in  1  synchronous reset, active-high
i_opcode  in  6  instr[31:26] from datapath IR, stable from DECODE onward
i_mem_ready  in  1  memory completes the current access this cycle
o_pc_write  out  1  unconditional PC load
o_pc_write_cond  out  1  PC load qualified by ALU zero (datapath: zero XOR o_branch_ne)
o_branch_ne  out  1  1 for bne
o_iord  out  1  0=PC, 1=ALUOut address
o_mem_read  out  1  memory read strobe
o_mem_write  out  1  memory write strobe
o_ir_write  out  1  IR load
o_reg_dst  out  2  00=rt, 01=rd, 10=r31
o_mem_to_reg  out  1  1=MDR to write data
o_pc_to_reg  out  1  1=PC to write data (jal)
o_reg_write  out  1  register-file write enable
o_alu_src_a  out  1  0=PC, 1=rs
o_alu_src_b  out  2  00=rt, 01=const 4, 10=ext imm, 11=ext imm<<2
o_alu_op  out  4  ALU operation class, see package
o_ext_mode  out  1  1=sign, 0=zero extend
o_pc_source  out  2  00=ALU result, 01=ALUOut, 10=jump target
o_illegal  out  1  sticky: undefined opcode trapped
o_bus_err  out  1  sticky: memory timeout trapped
o_retired  out  CNT_W  retired-instruction count, wraps modulo 2^CNT_W

Behaviour:
- Outputs are decoded from the registered state only. Unlisted outputs are 0 in every state.
- Reset:
  - Synchronous, takes effect on the next edge, including mid-instruction.
  - Resulting values: state=FETCH, o_illegal=0, o_bus_err=0, o_retired=0, wait counter=0.
  - While i_rst=1, all write enables and strobes are forced 0.
- FETCH:
  - Asserts iord=0, mem_read=1, alu_src_a=0, alu_src_b=01, alu_op=ADD, pc_source=00.
  - ir_write and pc_write are asserted only when i_mem_ready=1; transition to DECODE.
  - Otherwise stay in FETCH.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=ADD, ext_mode=1. Dispatch by opcode:
  - R-type 000000 → EXEC
  - lw 100011 / sw 101011 → MEMADR
  - beq 000100 / bne 000101 → BRANCH
  - j 000010 / jal 000011 → JUMP
  - addi 001000 / slti 001010 / andi 001100 / ori 001101 → IEXEC
  - any other opcode → TRAP with o_illegal set
- MEMADR: alu_src_a=1, alu_src_b=10, ADD, ext_mode=1. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD: iord=1, mem_read=1. On ready → MEMWB.
- MEMWB: reg_dst=00, mem_to_reg=1, reg_write=1 → FETCH.
- MEMWR: iord=1, mem_write held high. On ready → FETCH.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=FUNCT → RWB.
- RWB: reg_dst=01, reg_write=1 → FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, SUB, pc_write_cond=1, pc_source=01, branch_ne=(opcode==bne) → FETCH.
- JUMP: pc_source=10, pc_write=1. For jal, additionally reg_dst=10, pc_to_reg=1, reg_write=1, writing the already-incremented PC → FETCH.
- IEXEC: alu_src_a=1, alu_src_b=10.
  - alu_op: ADD for addi, SLT for slti, AND for andi, OR for ori.
  - ext_mode=0 for andi/ori, 1 otherwise.
  - → IWB.
- IWB: reg_dst=00, reg_write=1, same alu_op and ext_mode as IEXEC → FETCH.
- Wait counter (FETCH/MEMRD/MEMWR):
  - Increments each cycle the state waits with i_mem_ready=0; cleared on state exit.
  - Reaching TIMEOUT → TRAP with o_bus_err set.
  - If i_mem_ready=1 on the same cycle TIMEOUT is reached, the access completes; no error is raised.
- TRAP: all enables 0. Exited only by reset.
- o_retired increments by 1 on the final-state edge into FETCH from MEMWB, MEMWR, RWB, BRANCH, JUMP or IWB. It never increments from TRAP.
- Latency with ready=1 every cycle: R/addi-class 4 cycles, lw 5, sw 4, beq/bne 3, j/jal 3.

Decomposition:
- Package mc_ctrl_pkg holds:
  - state encoding: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, RWB, BRANCH, JUMP, IEXEC, IWB, TRAP
  - opcode constants
  - ALUOp constants: ADD=0, SUB=1, FUNCT=2, AND=3, OR=4, SLT=5
  - mux-select constants
- Sub-module mc_op_decode: combinational opcode → instruction class plus IEXEC alu_op/ext_mode.

Test Plan:
- Reset mid-MEMRD (i_rst=1 for one cycle) → next cycle state FETCH, all strobes 0 during reset, o_retired=0.
- Opcode 000000, ready=1 → states FETCH, DECODE, EXEC, RWB; RWB has reg_dst=01, reg_write=1; o_retired 0→1 after 4 cycles.
- lw with ready low 3 cycles in MEMRD → mem_read/iord=1 held 4 cycles, then MEMWB with mem_to_reg=1; total 8 cycles.
- bne → BRANCH with pc_write_cond=1, branch_ne=1, pc_source=01; jal → JUMP with pc_write=1, reg_dst=10, pc_to_reg=1, reg_write=1.
- ori → IEXEC with alu_op=4, ext_mode=0, alu_src_b=10; opcode 111111 → TRAP, o_illegal=1 held, no further enables.
- FETCH with ready never asserted, TIMEOUT=16 → TRAP after 16 waiting cycles, o_bus_err=1; ready rising on cycle 16 → normal fetch, o_bus_err=0.
